fir_decimator: RTL and testbench

Downstream stage for the 3-tap FIR filter output. Takes the filter's 16-bit unsigned output sample stream and averages each block of 2^DECIM_LOG2 consecutive valid samples, with rounding. Delivers one decimated sample per block through a 2-entry output buffer with a valid/ready handshake. Feeds the slower back-end (serializer or DAC interface); a full buffer drops the result and flags it rather than stalling the filter.

---
 rtl/fir_decimator.sv | 113 +++++++++++
 tb/tb_fir_decimator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// fir_decimator: block-average decimator with round-half-up and a 2-entry
// output buffer.
//
// Each block of N = 2^DECIM_LOG2 valid input samples is summed and divided
// by N with rounding. The result goes into a 2-deep FIFO that drains through
// a valid/ready port. The input side never stalls: if the buffer is full and
// nothing pops in the same cycle, the result is dropped and a sticky
// overflow flag is raised.
//
// Handshake: a word transfers on a rising clk edge where dout_valid and
// dout_ready are both 1. dout holds its value while dout_valid && !dout_ready.
// din has no ready signal; din_valid alone qualifies a sample.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   din         unsigned input sample (W bits)
//   din_valid   din carries a sample this cycle
//   dout        decimated sample at buffer head (registered)
//   dout_valid  dout holds a valid sample (registered)
//   dout_ready  consumer takes dout this cycle
//   overflow    sticky: a result was dropped on a full buffer
//   phase       samples accumulated in the current block, 0..N-1
module fir_decimator #(
  parameter int DECIM_LOG2 = 2,
  parameter int W          = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [W-1:0]                               din,
  input  logic                                       din_valid,
  output logic [W-1:0]                               dout,
  output logic                                       dout_valid,
  input  logic                                       dout_ready,
  output logic                                       overflow,
  output logic [((DECIM_LOG2 > 0) ? DECIM_LOG2 : 1)-1:0] phase
);

  localparam int N  = 1 << DECIM_LOG2;
  localparam int AW = W + DECIM_LOG2;
  localparam int PW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

  localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);
  // N/2 rounding term; zero when N=1, so the result is din unchanged.
  localparam logic [AW-1:0] ROUND_TERM = AW'(N / 2);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [W-1:0]  result;
  logic          close;
  logic          pop;

  // Buffer is split into a head register (drives dout) and one tail slot.
  logic [W-1:0]  tail;
  logic          tail_valid;

  // The block total plus rounding term cannot exceed N*2^W - 1, so AW bits
  // never wrap and the shifted result always fits in W bits.
  always_comb begin
    close  = din_valid && (phase == LAST_PHASE);
    sum    = acc + AW'(din) + ROUND_TERM;
    result = W'(sum >> DECIM_LOG2);
    pop    = dout_valid && dout_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      phase      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      tail       <= '0;
      tail_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Accumulator and block phase
      if (close) begin
        acc   <= '0;
        phase <= '0;
      end else if (din_valid) begin
        acc   <= acc + AW'(din);
        phase <= phase + 1'b1;
      end

      // Output buffer
      if (pop) begin
        if (tail_valid) begin
          dout <= tail;
          if (close) begin
            tail <= result;
          end else begin
            tail_valid <= 1'b0;
          end
        end else if (close) begin
          dout <= result;
        end else begin
          dout_valid <= 1'b0;
        end
      end else if (close) begin
        if (!dout_valid) begin
          dout       <= result;
          dout_valid <= 1'b1;
        end else if (!tail_valid) begin
          tail       <= result;
          tail_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Testbench for fir_decimator. Two instances share the clock: one with
// N=4 (DECIM_LOG2=2) and one with N=1 (DECIM_LOG2=0). Directed vectors come
// from a table; multi-cycle buffer/reset cases are hand-written; a random
// phase compares each instance against a queue-based reference model.
module tb_fir_decimator;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst4, v4, r4, dv4, ov4;
  logic [W-1:0] din4, dout4;
  logic [1:0]   ph4;

  logic         rst1, v1, r1, dv1, ov1;
  logic [W-1:0] din1, dout1;
  logic [0:0]   ph1;

  fir_decimator #(.DECIM_LOG2(2), .W(W)) dut4 (
    .clk(clk), .rst(rst4), .din(din4), .din_valid(v4),
    .dout(dout4), .dout_valid(dv4), .dout_ready(r4),
    .overflow(ov4), .phase(ph4)
  );

  fir_decimator #(.DECIM_LOG2(0), .W(W)) dut1 (
    .clk(clk), .rst(rst1), .din(din1), .din_valid(v1),
    .dout(dout1), .dout_valid(dv1), .dout_ready(r1),
    .overflow(ov1), .phase(ph1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int           blk[$];
  logic [W-1:0] exp_q[$];
  bit           m_ov;

  task automatic model_reset();
    blk.delete();
    exp_q.delete();
    m_ov = 0;
  endtask

  // One clock edge of behaviour: block average of N samples, 2-deep FIFO.
  task automatic model_step(input int n, input bit v, input int d, input bit r);
    bit  do_pop, do_push;
    int  total;
    logic [W-1:0] res;
    do_pop  = (exp_q.size() > 0) && r;
    do_push = 0;
    res     = '0;
    if (v) begin
      blk.push_back(d);
      if (blk.size() == n) begin
        total = 0;
        foreach (blk[i]) total += blk[i];
        res = W'((total + n / 2) / n);
        blk.delete();
        do_push = 1;
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      if (exp_q.size() < 2) exp_q.push_back(res);
      else m_ov = 1;
    end
  endtask

  task automatic model_check(input string tag, input logic dv, input logic [W-1:0] d,
                             input logic ov, input int ph);
    chk({tag, "_dout_valid"}, dv, exp_q.size() > 0);
    if (exp_q.size() > 0) chk({tag, "_dout"}, d, exp_q[0]);
    chk({tag, "_overflow"}, ov, m_ov);
    chk({tag, "_phase"}, ph, blk.size());
  endtask

  // ---------------- directed vector table (N=4) ----------------
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         edv;
    logic [W-1:0] ed;
    logic [1:0]   eph;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [W-1:0] d, logic r,
                              logic edv, logic [W-1:0] ed, logic [1:0] eph);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.edv = edv; t.ed = ed; t.eph = eph;
    return t;
  endfunction

  initial begin
    rst4 = 1; v4 = 0; din4 = 0; r4 = 0;
    rst1 = 1; v1 = 0; din1 = 0; r1 = 0;
    step();
    rst4 = 0; rst1 = 0;

    // Reset state of both instances
    chk("rst4_dout", dout4, 0);
    chk("rst4_dv", dv4, 0);
    chk("rst4_ov", ov4, 0);
    chk("rst4_phase", ph4, 0);
    chk("rst1_dout", dout1, 0);
    chk("rst1_dv", dv1, 0);
    chk("rst1_ov", ov1, 0);
    chk("rst1_phase", ph1, 0);

    // 10,11,12,13 -> (46+2)>>2 = 12, valid for exactly one cycle
    vecs.push_back(mk(1, 10, 1, 0, 0, 1));
    vecs.push_back(mk(1, 11, 1, 0, 0, 2));
    vecs.push_back(mk(1, 12, 1, 0, 0, 3));
    vecs.push_back(mk(1, 13, 1, 1, 12, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0));
    // full-scale block, no wrap
    vecs.push_back(mk(1, 16'hFFFF, 1, 0, 0, 1));
    vecs.push_back(mk(1, 16'hFFFF, 1, 0, 0, 2));
    vecs.push_back(mk(1, 16'hFFFF, 1, 0, 0, 3));
    vecs.push_back(mk(1, 16'hFFFF, 1, 1, 16'hFFFF, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0));
    // round half up: (2+2)>>2 = 1
    vecs.push_back(mk(1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 2));
    vecs.push_back(mk(1, 0, 1, 0, 0, 3));
    vecs.push_back(mk(1, 2, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0));
    // gaps hold phase: 4,8,12,16 -> (40+2)>>2 = 10
    vecs.push_back(mk(1, 4, 1, 0, 0, 1));
    vecs.push_back(mk(0, 99, 1, 0, 0, 1));
    vecs.push_back(mk(1, 8, 1, 0, 0, 2));
    vecs.push_back(mk(0, 99, 1, 0, 0, 2));
    vecs.push_back(mk(1, 12, 1, 0, 0, 3));
    vecs.push_back(mk(0, 99, 1, 0, 0, 3));
    vecs.push_back(mk(1, 16, 1, 1, 10, 0));
    vecs.push_back(mk(0, 99, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      v4 = vecs[i].v; din4 = vecs[i].d; r4 = vecs[i].r;
      step();
      chk($sformatf("vec%0d_dv", i), dv4, vecs[i].edv);
      if (vecs[i].edv) chk($sformatf("vec%0d_dout", i), dout4, vecs[i].ed);
      chk($sformatf("vec%0d_phase", i), ph4, vecs[i].eph);
    end
    chk("vec_ov", ov4, 0);

    // ---------------- reset mid-block (N=4) ----------------
    v4 = 1; r4 = 1;
    din4 = 100; step();
    din4 = 200; step();
    rst4 = 1; din4 = 999; step();      // reset overrides the sample
    rst4 = 0;
    chk("mid_rst_dv", dv4, 0);
    chk("mid_rst_phase", ph4, 0);
    for (int k = 0; k < 4; k++) begin
      din4 = 20; step();
    end
    v4 = 0;
    chk("mid_rst_dv_after", dv4, 1);
    chk("mid_rst_dout", dout4, 20);
    chk("mid_rst_phase_after", ph4, 0);

    // ---------------- N=1 overflow with consumer stalled ----------------
    rst1 = 1; step(); rst1 = 0;
    r1 = 0; v1 = 1;
    din1 = 5; step();
    chk("ovf_dout_a", dout1, 5);
    chk("ovf_dv_a", dv1, 1);
    chk("ovf_ov_a", ov1, 0);
    din1 = 6; step();
    chk("ovf_dout_b", dout1, 5);
    chk("ovf_ov_b", ov1, 0);
    din1 = 7; step();
    chk("ovf_dout_c", dout1, 5);
    chk("ovf_ov_c", ov1, 1);
    v1 = 0; r1 = 1; step();
    chk("ovf_drain_1", dout1, 6);
    chk("ovf_drain_dv1", dv1, 1);
    step();
    chk("ovf_drain_dv2", dv1, 0);
    chk("ovf_sticky", ov1, 1);

    // ---------------- full buffer with simultaneous pop ----------------
    rst1 = 1; step(); rst1 = 0;
    chk("fp_rst_ov", ov1, 0);
    r1 = 0; v1 = 1;
    din1 = 5; step();
    din1 = 6; step();
    chk("fp_head5", dout1, 5);
    din1 = 7; r1 = 1; step();
    v1 = 0;
    chk("fp_ov", ov1, 0);
    chk("fp_head6", dout1, 6);
    step();
    chk("fp_head7", dout1, 7);
    chk("fp_dv7", dv1, 1);
    step();
    chk("fp_empty", dv1, 0);
    chk("fp_ov_end", ov1, 0);

    // ---------------- random vs model, N=4 ----------------
    rst4 = 1; step(); rst4 = 0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      v4 = ($urandom_range(0, 9) < 7);
      din4 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : W'($urandom_range(0, 65535));
      r4 = ($urandom_range(0, 9) < (c < 300 ? 8 : 2));
      step();
      model_step(4, v4, din4, r4);
      model_check("rnd4", dv4, dout4, ov4, ph4);
    end

    // ---------------- random vs model, N=1, ready held high ----------------
    rst1 = 1; step(); rst1 = 0;
    model_reset();
    r1 = 1;
    for (int c = 0; c < 200; c++) begin
      v1 = 1;
      din1 = W'($urandom_range(0, 65535));
      step();
      model_step(1, v1, din1, r1);
      model_check("tput1", dv1, dout1, ov1, ph1);
    end
    chk("tput1_no_ov", ov1, 0);

    // ---------------- random vs model, N=1, random ready ----------------
    for (int c = 0; c < 300; c++) begin
      v1 = ($urandom_range(0, 1) == 1);
      din1 = W'($urandom_range(0, 65535));
      r1 = ($urandom_range(0, 9) < 4);
      step();
      model_step(1, v1, din1, r1);
      model_check("rnd1", dv1, dout1, ov1, ph1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
